// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared state encoding, PC source codes and default vectors.
package pc_sequencer_pkg;
    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_IRQ    = 3'd4,
        ST_HALTED = 3'd5
    } state_e;
    typedef enum logic [2:0] {
        SRC_HOLD   = 3'd0,
        SRC_SEQ    = 3'd1,
        SRC_JUMP   = 3'd2,
        SRC_BRANCH = 3'd3,
        SRC_EPC    = 3'd4,
        SRC_RESET  = 3'd5,
        SRC_IRQ    = 3'd6
    } pc_src_e;
    localparam logic [15:0] RESET_VECTOR_DEF = 16'h0000;
    localparam logic [15:0] IRQ_VECTOR_DEF   = 16'h0100;
    localparam logic [15:0] PC_STEP_DEF      = 16'd2;
endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: selects the value presented to the PC register input.
module pc_next_mux
    import pc_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [15:0] IRQ_VECTOR   = IRQ_VECTOR_DEF,
    parameter logic [15:0] PC_STEP      = PC_STEP_DEF
) (
    input  pc_src_e     src_i,
    input  logic [15:0] pc_i,
    input  logic [15:0] jump_target_i,
    input  logic [15:0] branch_target_i,
    input  logic [15:0] epc_i,
    output logic [15:0] pc_next_o
);
    logic [15:0] pc_seq;
    assign pc_seq = pc_i + PC_STEP;
    always_comb begin
        pc_next_o = (src_i == SRC_SEQ)    ? pc_seq :
                    (src_i == SRC_JUMP)   ? jump_target_i :
                    (src_i == SRC_BRANCH) ? branch_target_i :
                    (src_i == SRC_EPC)    ? epc_i :
                    (src_i == SRC_RESET)  ? RESET_VECTOR :
                    (src_i == SRC_IRQ)    ? IRQ_VECTOR : pc_i;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle fetch/decode/execute control that owns the PC write path,
// including interrupt entry/return and halt.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [15:0] IRQ_VECTOR   = IRQ_VECTOR_DEF,
    parameter logic [15:0] PC_STEP      = PC_STEP_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] pc,
    output logic [15:0] pc_next,
    output logic        pc_write,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        ir_write,
    output logic        decode_en,
    input  logic        exec_done,
    input  logic        halt,
    input  logic        jump,
    input  logic [15:0] jump_target,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        iret,
    input  logic        irq,
    output logic        irq_ack,
    output logic [15:0] epc,
    output logic        halted
);
    state_e      state_q, state_d;
    logic [15:0] epc_q, epc_d;
    logic        irq_en_q, irq_en_d;
    pc_src_e     src;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_BOOT;
            epc_q    <= 16'h0000;
            irq_en_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            epc_q    <= epc_d;
            irq_en_q <= irq_en_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        epc_d     = epc_q;
        irq_en_d  = irq_en_q;
        src       = SRC_HOLD;
        imem_req  = 1'b0;
        ir_write  = 1'b0;
        decode_en = 1'b0;
        irq_ack   = 1'b0;
        halted    = 1'b0;
        case (state_q)
            ST_BOOT: begin
                src     = SRC_RESET;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_write = 1'b1;
                    src      = SRC_SEQ;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                decode_en = 1'b1;
                state_d   = ST_EXEC;
            end
            ST_EXEC: begin
                if (exec_done) begin
                    if (halt) begin
                        state_d = ST_HALTED;
                    end else begin
                        src = iret ? SRC_EPC : jump ? SRC_JUMP : branch_taken ? SRC_BRANCH : SRC_HOLD;
                        if (iret) irq_en_d = 1'b1;
                        // iret re-enables interrupts in the same cycle, allowing immediate re-entry
                        state_d = (irq && (irq_en_q || iret)) ? ST_IRQ : ST_FETCH;
                    end
                end
            end
            ST_IRQ: begin
                epc_d    = pc;
                src      = SRC_IRQ;
                irq_ack  = 1'b1;
                irq_en_d = 1'b0;
                state_d  = ST_FETCH;
            end
            ST_HALTED: begin
                halted = 1'b1;
                if (irq && irq_en_q) state_d = ST_IRQ;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    assign pc_write = (src != SRC_HOLD);
    assign epc      = epc_q;

    pc_next_mux #(
        .RESET_VECTOR(RESET_VECTOR),
        .IRQ_VECTOR  (IRQ_VECTOR),
        .PC_STEP     (PC_STEP)
    ) u_mux (
        .src_i          (src),
        .pc_i           (pc),
        .jump_target_i  (jump_target),
        .branch_target_i(branch_target),
        .epc_i          (epc_q),
        .pc_next_o      (pc_next)
    );
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of the PC sequencer against an external PC register.
module tb_pc_sequencer;
    logic        clock = 1'b0;
    logic        reset, imem_ack, exec_done, halt, jump, branch_taken, iret, irq;
    logic [15:0] jump_target, branch_target;
    logic [15:0] pc = 16'hABCD;
    logic [15:0] pc_next, epc;
    logic        pc_write, imem_req, ir_write, decode_en, irq_ack, halted;
    int          checks = 0;
    int          passes = 0;

    pc_sequencer dut (
        .clock(clock), .reset(reset), .pc(pc), .pc_next(pc_next), .pc_write(pc_write),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_write(ir_write), .decode_en(decode_en),
        .exec_done(exec_done), .halt(halt), .jump(jump), .jump_target(jump_target),
        .branch_taken(branch_taken), .branch_target(branch_target), .iret(iret), .irq(irq),
        .irq_ack(irq_ack), .epc(epc), .halted(halted)
    );

    always #5 clock = ~clock;

    // external PC register
    always @(posedge clock) if (pc_write) pc <= pc_next;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // FETCH with ack after wait_n cycles, then DECODE; ends in EXEC
    task automatic fetch(input logic [15:0] exp_pc, input logic [15:0] exp_next, input int wait_n);
        for (int i = 0; i < wait_n; i++) begin
            #1;
            chk("fetch_req", {15'd0, imem_req}, 16'd1);
            chk("fetch_irw_idle", {15'd0, ir_write}, 16'd0);
            chk("fetch_pcw_idle", {15'd0, pc_write}, 16'd0);
            tick();
        end
        imem_ack = 1'b1;
        #1;
        chk("fetch_pc", pc, exp_pc);
        chk("fetch_irw", {15'd0, ir_write}, 16'd1);
        chk("fetch_pcw", {15'd0, pc_write}, 16'd1);
        chk("fetch_next", pc_next, exp_next);
        chk("fetch_dec_early", {15'd0, decode_en}, 16'd0);
        tick();
        imem_ack = 1'b0;
        #1;
        chk("decode_en", {15'd0, decode_en}, 16'd1);
        chk("decode_pcw", {15'd0, pc_write}, 16'd0);
        chk("decode_irw", {15'd0, ir_write}, 16'd0);
        tick();
    endtask

    // one idle EXEC cycle, then exec_done with the given flags
    task automatic exec(input logic h, input logic ir, input logic j, input logic [15:0] jt,
                        input logic b, input logic [15:0] bt, input logic exp_w, input logic [15:0] exp_next);
        #1;
        chk("exec_wait_pcw", {15'd0, pc_write}, 16'd0);
        chk("exec_wait_dec", {15'd0, decode_en}, 16'd0);
        tick();
        exec_done = 1'b1; halt = h; iret = ir; jump = j; jump_target = jt;
        branch_taken = b; branch_target = bt;
        #1;
        chk("exec_pcw", {15'd0, pc_write}, {15'd0, exp_w});
        if (exp_w) chk("exec_next", pc_next, exp_next);
        tick();
        exec_done = 1'b0; halt = 1'b0; iret = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        jump_target = 16'h0; branch_target = 16'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; imem_ack = 1'b0; exec_done = 1'b0; halt = 1'b0; jump = 1'b0;
        branch_taken = 1'b0; iret = 1'b0; irq = 1'b0; jump_target = 16'h0; branch_target = 16'h0;
        @(negedge clock);
        tick();
        reset = 1'b0;
        #1;
        chk("boot_pcw", {15'd0, pc_write}, 16'd1);
        chk("boot_next", pc_next, 16'h0000);
        chk("boot_req", {15'd0, imem_req}, 16'd0);
        chk("boot_epc", epc, 16'h0000);
        chk("boot_halted", {15'd0, halted}, 16'd0);
        tick();
        // sequential fetches
        fetch(16'h0000, 16'h0002, 3); exec(0, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        fetch(16'h0002, 16'h0004, 3); exec(0, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        fetch(16'h0004, 16'h0006, 3); exec(0, 0, 1, 16'h0010, 0, 16'h0, 1, 16'h0010);
        // jump beats branch, then branch alone
        fetch(16'h0010, 16'h0012, 0); exec(0, 0, 1, 16'h0400, 1, 16'h0200, 1, 16'h0400);
        fetch(16'h0400, 16'h0402, 0); exec(0, 0, 0, 16'h0, 1, 16'h0200, 1, 16'h0200);
        fetch(16'h0200, 16'h0202, 1); exec(0, 0, 1, 16'h0020, 0, 16'h0, 1, 16'h0020);
        // interrupt entry at EXEC completion with pc=0022
        fetch(16'h0020, 16'h0022, 0);
        irq = 1'b1;
        exec(0, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        #1;
        chk("irq_ack", {15'd0, irq_ack}, 16'd1);
        chk("irq_next", pc_next, 16'h0100);
        chk("irq_pcw", {15'd0, pc_write}, 16'd1);
        tick();
        #1;
        chk("irq_epc", epc, 16'h0022);
        chk("irq_ack_pulse", {15'd0, irq_ack}, 16'd0);
        // irq still high but masked: no re-entry
        fetch(16'h0100, 16'h0102, 0); exec(0, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        #1;
        chk("masked_req", {15'd0, imem_req}, 16'd1);
        chk("masked_ack", {15'd0, irq_ack}, 16'd0);
        // iret with irq high: return to 0022 then immediate re-entry
        fetch(16'h0102, 16'h0104, 0); exec(0, 1, 0, 16'h0, 0, 16'h0, 1, 16'h0022);
        #1;
        chk("reentry_ack", {15'd0, irq_ack}, 16'd1);
        chk("reentry_pc", pc, 16'h0022);
        tick();
        irq = 1'b0;
        #1;
        chk("reentry_epc", epc, 16'h0022);
        // wrap at FFFE
        fetch(16'h0100, 16'h0102, 0); exec(0, 0, 1, 16'hFFFE, 0, 16'h0, 1, 16'hFFFE);
        fetch(16'hFFFE, 16'h0000, 1); exec(0, 1, 0, 16'h0, 0, 16'h0, 1, 16'h0022);
        // halt outranks jump; halted ignores fetch and acks
        fetch(16'h0022, 16'h0024, 0); exec(1, 0, 1, 16'h0300, 0, 16'h0, 0, 16'h0);
        for (int i = 0; i < 20; i++) begin
            imem_ack = i[0];
            #1;
            chk("halt_req", {15'd0, imem_req}, 16'd0);
            chk("halt_flag", {15'd0, halted}, 16'd1);
            chk("halt_pcw", {15'd0, pc_write}, 16'd0);
            tick();
        end
        imem_ack = 1'b0;
        irq = 1'b1;
        tick();
        #1;
        chk("halt_irq_ack", {15'd0, irq_ack}, 16'd1);
        chk("halt_irq_next", pc_next, 16'h0100);
        tick();
        irq = 1'b0;
        #1;
        chk("halt_epc", epc, 16'h0024);
        chk("halt_resume_flag", {15'd0, halted}, 16'd0);
        fetch(16'h0100, 16'h0102, 2); exec(0, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        // reset while waiting for ack; a late ack in BOOT is ignored
        #1;
        chk("pre_reset_req", {15'd0, imem_req}, 16'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        imem_ack = 1'b1;
        #1;
        chk("rst_pcw", {15'd0, pc_write}, 16'd1);
        chk("rst_next", pc_next, 16'h0000);
        chk("rst_req", {15'd0, imem_req}, 16'd0);
        chk("rst_irw", {15'd0, ir_write}, 16'd0);
        chk("rst_epc", epc, 16'h0000);
        tick();
        imem_ack = 1'b0;
        #1;
        chk("rst_fetch_pc", pc, 16'h0000);
        chk("rst_fetch_req", {15'd0, imem_req}, 16'd1);
        chk("rst_fetch_dec", {15'd0, decode_en}, 16'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multicycle control sequencer that owns the program counter register. It drives the PC's data input and PCWrite strobe. It runs the fetch / decode / execute sequence against an instruction-memory handshake and selects the next PC value. Sources are sequential, jump, branch, interrupt vector and interrupt return.

Parameters:
RESET_VECTOR, 16'h0000, PC value loaded in the first cycle after reset
IRQ_VECTOR, 16'h0100, PC value loaded on interrupt entry
PC_STEP, 2, sequential increment (byte-addressed 16-bit instructions)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
pc  in  16  current PC register output
pc_next  out  16  value presented to the PC register input
pc_write  out  1  PC register write enable
imem_req  out  1  instruction fetch request, held until acknowledged
imem_ack  in  1  instruction memory has imem_data valid this cycle
ir_write  out  1  instruction register load strobe
decode_en  out  1  one-cycle strobe: instruction register valid, decode now
exec_done  in  1  datapath has finished executing the current instruction
halt  in  1  with exec_done: stop fetching
jump  in  1  with exec_done: take jump_target
jump_target  in  16  absolute jump address
branch_taken  in  1  with exec_done: take branch_target
branch_target  in  16  resolved branch address
iret  in  1  with exec_done: return from interrupt
irq  in  1  level-sensitive interrupt request
irq_ack  out  1  one-cycle pulse on interrupt entry
epc  out  16  saved return PC (registered)
halted  out  1  high while in HALTED

Behaviour:
- States: BOOT, FETCH, DECODE, EXEC, IRQ, HALTED. State, epc and irq_en are registered. All other outputs are combinational from state and inputs, and default to 0 / pc_next=pc.
- Reset, at the clock edge with reset=1: state<=BOOT, epc<=0, irq_en<=1. Reset overrides every other input, including mid-fetch; imem_req is 0 from the next cycle.
- BOOT: pc_write=1, pc_next=RESET_VECTOR; next state FETCH.
- FETCH:
  - imem_req=1.
  - If imem_ack=1: ir_write=1, pc_write=1, pc_next=pc+PC_STEP (mod 2^16, wraps FFFE->0000); next state DECODE.
  - Otherwise stay; no timeout, unbounded wait.
- DECODE: decode_en=1 for exactly one cycle; next state EXEC.
- EXEC: wait for exec_done. When exec_done=1, apply the first matching case in priority order:
  - halt: no PC write; next state HALTED.
  - iret: pc_write=1, pc_next=epc, irq_en<=1.
  - jump: pc_write=1, pc_next=jump_target.
  - branch_taken: pc_write=1, pc_next=branch_target.
  - else: no PC write.
  - Next state (unless halt): IRQ if irq=1 and irq_en=1, else FETCH. The iret case counts irq_en as 1 in that cycle, so back-to-back interrupt entry is allowed.
- IRQ:
  - epc<=pc. The redirected PC is already visible because the register updated at the previous edge.
  - pc_write=1, pc_next=IRQ_VECTOR, irq_ack=1, irq_en<=0; next state FETCH.
- HALTED: halted=1, no fetch. irq=1 with irq_en=1 goes to IRQ; otherwise stay until reset.
- Ignored inputs:
  - imem_ack outside FETCH and exec_done outside EXEC are ignored.
  - irq is sampled only at EXEC completion and in HALTED, never mid-instruction.
- pc_write is never asserted in DECODE. At most one PC write per cycle.
- Unreachable state encodings return to BOOT.

Decomposition:
- Shared package (used by the control unit and the bench):
  - state encoding constants (3-bit): BOOT=0, FETCH=1, DECODE=2, EXEC=3, IRQ=4, HALTED=5
  - PC source codes
  - default vectors
- One natural sub-module, pc_next_mux: combinational select of pc+PC_STEP / jump_target / branch_target / epc / vectors.
- The FSM stays in pc_sequencer.

Test Plan:
1. Reset, then imem_ack returned 3 cycles after each request, exec_done with no redirect → PC sequence 0000, 0002, 0004.
   - ir_write pulses once per fetch.
   - decode_en is high exactly 1 cycle after each ack.
2. PC=0010, exec_done with jump=1 (jump_target=0400) and branch_taken=1 (branch_target=0200) → next fetch at 0400.
   - Repeat with jump=0 → next fetch at 0200.
3. irq=1 during EXEC at PC=0022 → fetch at 0100, irq_ack for one pulse, epc=0022.
   - irq still high at the next EXEC completion → no re-entry.
   - exec_done with iret=1 → PC=0022, re-entry possible.
4. PC=FFFE, fetch acked → pc_next=0000 (wrap).
5. exec_done with halt=1 → halted=1, imem_req stays 0 for 20 cycles.
   - irq=1 → IRQ entry with epc equal to PC at halt, fetch resumes at 0100.
6. Reset asserted while imem_req=1 waiting for ack → next cycle BOOT, pc_write=1, pc_next=0000, imem_req=0.
   - A late imem_ack arriving in BOOT is ignored.
